tnn_neuron_seq: RTL and testbench

Sequential, parametrised ternary-weight neuron for the tree-NN classifier datapath. It replaces the fixed 9-input, 2-bit, fully combinational positive-sum vs negative-sum comparator with a streaming unit. The unit accepts one weighted input per beat, accumulates a saturating signed sum over a frame of `N_INPUTS` beats, compares it against a per-frame threshold, and returns a one-bit decision through a valid/ready handshake. It sits between the feature-quantiser stream and the tree-node output register.

---
 rtl/tnn_neuron_seq.sv | 139 +++++++++++++
 tb/tb_tnn_neuron_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tnn_neuron_seq.sv
// tnn_neuron_seq
// Streaming ternary-weight neuron. It takes one weighted operand per beat
// and accumulates a saturating signed sum over N_INPUTS beats. It then
// holds a one-bit decision (acc > threshold) until downstream accepts it.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input beat handshake
//   in_data  [IN_W]      unsigned operand
//   in_weight[2]         ternary code: 01 = +1, 11 = -1, 00/10 = 0
//   in_thresh[ACC_W]     signed threshold, taken from the first beat only
//   out_valid/out_ready  decision handshake
//   out_bit              acc > thresh (signed)
//   out_sum  [ACC_W]     final saturated accumulator
//   out_sat              any clamp occurred during the frame
module tnn_neuron_seq #(
    parameter int N_INPUTS = 9,
    parameter int IN_W     = 2,
    parameter int ACC_W    = 8,
    parameter int CNT_W    = $clog2(N_INPUTS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_data,
    input  logic [1:0]              in_weight,
    input  logic signed [ACC_W-1:0] in_thresh,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_bit,
    output logic [ACC_W-1:0]        out_sum,
    output logic                    out_sat
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] thresh_r;
    logic [CNT_W-1:0]        cnt;
    logic                    sat;

    logic signed [ACC_W-1:0] mag;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W:0]   wide;
    logic signed [ACC_W-1:0] add_res;
    logic                    add_ovf;
    logic [CNT_W-1:0]        cnt_next;

    // Signed weighted term; reserved code 10 behaves as zero weight.
    always_comb begin
        mag  = $signed({{(ACC_W-IN_W){1'b0}}, in_data});
        term = '0;
        case (in_weight)
            2'b01:   term = mag;
            2'b11:   term = -mag;
            default: term = '0;
        endcase
    end

    // One extra bit of headroom exposes overflow as a mismatch between the
    // top two bits; the sign of the wide sum selects which rail to clamp to.
    always_comb begin
        wide    = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
        add_ovf = 1'b0;
        add_res = wide[ACC_W-1:0];
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            add_ovf = 1'b1;
            add_res = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    assign cnt_next = cnt + CNT_W'(1);

    // Decision outputs come only from registers, so there is no
    // combinational path from the input stream.
    assign out_bit = (acc > thresh_r);
    assign out_sum = acc;
    assign out_sat = sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            thresh_r  <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        acc      <= term;
                        thresh_r <= in_thresh;
                        cnt      <= CNT_W'(1);
                        sat      <= 1'b0;
                        if (N_INPUTS == 1) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc <= add_res;
                        sat <= sat | add_ovf;
                        cnt <= cnt_next;
                        if (cnt_next == CNT_W'(N_INPUTS)) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tnn_neuron_seq.sv
// Directed testbench for tnn_neuron_seq. It runs two instances on shared
// stimulus: the default ACC_W=8 one and an ACC_W=4 one that saturates.
module tb_tnn_neuron_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_data;
    logic [1:0] in_weight;
    logic [7:0] in_thresh;
    logic       out_ready;

    logic       in_ready, out_valid, out_bit, out_sat;
    logic [7:0] out_sum;
    logic       s_in_ready, s_out_valid, s_out_bit, s_out_sat;
    logic [3:0] s_out_sum;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tnn_neuron_seq #(.N_INPUTS(9), .IN_W(2), .ACC_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_weight(in_weight), .in_thresh(in_thresh),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
        .out_sum(out_sum), .out_sat(out_sat)
    );

    tnn_neuron_seq #(.N_INPUTS(9), .IN_W(2), .ACC_W(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_weight(in_weight), .in_thresh(in_thresh[3:0]),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_bit(s_out_bit),
        .out_sum(s_out_sum), .out_sat(s_out_sat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until it is accepted (bounded).
    task automatic send_beat(input logic [1:0] w, input logic [1:0] d, input logic [7:0] th);
        int n = 0;
        in_valid  = 1'b1;
        in_weight = w;
        in_data   = d;
        in_thresh = th;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("beat_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Nine beats. The threshold is th_first on beat 0 and th_rest afterwards.
    // gaps[i] idle cycles follow beat i.
    task automatic send_frame(input logic [1:0] w[9], input logic [1:0] d[9],
                              input logic [7:0] th_first, input logic [7:0] th_rest,
                              input int gaps[9]);
        for (int i = 0; i < 9; i++) begin
            send_beat(w[i], d[i], (i == 0) ? th_first : th_rest);
            if (i < 8) for (int g = 0; g < gaps[i]; g++) tick();
        end
    endtask

    // Wait for the decision, check it, then complete the handshake.
    task automatic take_result(input string tag, input logic [7:0] sum, input logic b,
                               input logic s);
        int n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"}, {24'd0, out_sum}, {24'd0, sum});
        check({tag, "_bit"}, {31'd0, out_bit}, {31'd0, b});
        check({tag, "_sat"}, {31'd0, out_sat}, {31'd0, s});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_done"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    logic [1:0] w_basic[9] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00};
    logic [1:0] w_pos[9]   = '{default: 2'b01};
    logic [1:0] w_neg[9]   = '{default: 2'b11};
    logic [1:0] w_rsv[9]   = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [1:0] d3[9]      = '{default: 2'd3};
    logic [1:0] d2[9]      = '{default: 2'd2};
    int         nogap[9]   = '{default: 0};
    int         gaps[9]    = '{2, 0, 1, 3, 0, 0, 1, 2, 0};
    logic [7:0] hold_sum;
    logic       hold_bit;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_weight = '0;
        in_thresh = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_state", {27'd0, in_ready, out_valid, out_bit, out_sat, 1'b0},
              {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        check("rst_sum", {24'd0, out_sum}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic decision with latency check. out_ready stays high throughout.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send_beat(w_basic[i], 2'd3, 8'd0);
            if (i == 7) check("lat_before", {31'd0, out_valid}, 32'd0);
        end
        check("lat_after", {31'd0, out_valid}, 32'd1);
        check("basic_sum", {24'd0, out_sum}, 32'd6);
        check("basic_bit", {31'd0, out_bit}, 32'd1);
        check("basic_sat", {31'd0, out_sat}, 32'd0);
        tick();
        check("basic_done", {30'd0, out_valid, in_ready}, 32'd1);
        out_ready = 1'b0;

        // Threshold equality, and later changes to in_thresh are ignored.
        send_frame(w_basic, d3, 8'd6, 8'd6, nogap);
        take_result("th_eq", 8'd6, 1'b0, 1'b0);
        send_frame(w_basic, d3, 8'd5, 8'd5, nogap);
        take_result("th_lt", 8'd6, 1'b1, 1'b0);
        send_frame(w_basic, d3, 8'd5, 8'd100, nogap);
        take_result("th_late_hi", 8'd6, 1'b1, 1'b0);
        send_frame(w_basic, d3, 8'd6, 8'hF0, nogap);
        take_result("th_late_lo", 8'd6, 1'b0, 1'b0);

        // Saturation. The ACC_W=4 instance clamps; the 8-bit one gives +-27.
        send_frame(w_pos, d3, 8'd0, 8'd0, nogap);
        check("satp_s_sum", {28'd0, s_out_sum}, 32'd7);
        check("satp_s_flags", {30'd0, s_out_sat, s_out_bit}, 32'd3);
        take_result("satp", 8'd27, 1'b1, 1'b0);
        send_frame(w_neg, d3, 8'd0, 8'd0, nogap);
        check("satn_s_sum", {28'd0, s_out_sum}, 32'd8);
        check("satn_s_sat", {31'd0, s_out_sat}, 32'd1);
        take_result("satn", 8'hE5, 1'b0, 1'b0);

        // Back-pressure: beats offered in HOLD must not be consumed.
        send_frame(w_basic, d3, 8'd0, 8'd0, nogap);
        hold_sum = out_sum;
        hold_bit = out_bit;
        in_valid = 1'b1; in_weight = 2'b01; in_data = 2'd3;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold", {22'd0, out_valid, in_ready, out_bit, out_sum},
                  {22'd0, 1'b1, 1'b0, hold_bit, 8'd6});
        end
        in_valid = 1'b0;
        take_result("bp_rel", 8'd6, 1'b1, 1'b0);
        send_frame(w_basic, d3, 8'd0, 8'd0, nogap);
        take_result("bp_next", 8'd6, 1'b1, 1'b0);

        // Bubbles inside a frame, and reserved code 10 counting as a beat.
        send_frame(w_basic, d3, 8'd0, 8'd0, gaps);
        take_result("bubble", 8'd6, 1'b1, 1'b0);
        send_frame(w_rsv, d2, 8'd1, 8'd1, nogap);
        check("rsv_lat", {31'd0, out_valid}, 32'd1);
        take_result("rsv", 8'd2, 1'b1, 1'b0);

        // Reset after beat 4 discards the partial frame.
        for (int i = 0; i < 4; i++) send_beat(2'b01, 2'd3, 8'd0);
        rst = 1'b1;
        tick();
        check("midrst", {19'd0, in_ready, out_valid, out_bit, out_sat, out_sum},
              {19'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
        rst = 1'b0;
        send_frame(w_basic, d3, 8'd0, 8'd0, nogap);
        take_result("post_rst", 8'd6, 1'b1, 1'b0);

        // Reset while a decision is pending.
        send_frame(w_basic, d3, 8'd0, 8'd0, nogap);
        check("hold_pre", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("hold_rst", {30'd0, out_valid, in_ready}, 32'd1);
        tick();
        check("hold_rst2", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
